id_branch_ctrl: RTL
===================

ID_BRANCH_CTRL -- requirements
Module: id_branch_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of both performance counters.
REQ-002 clock  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 if_id_nextpc  input  32  PC+4 of the instruction in if_id_instruc.
REQ-005 if_id_instruc  input  32  instruction in decode; MIPS-I encoding.
REQ-006 rs_data, rt_data  input  32 each  register-file read values for instr[25:21] and instr[20:16].
REQ-007 rs_busy, rt_busy  input  1 each  scoreboard: operand not yet written back.
REQ-008 ex_stall  input  1  execute stage cannot accept a new instruction.
REQ-009 exc_req  input  1  exception request; redirect to the vector at 0x40.
REQ-010 id_stall  output  1  fetch must hold PC and instruction.
REQ-011 id_if_selpcsource  output  1  redirect fetch this cycle.
REQ-012 id_if_selpctype  output  2  00 branch, 01 register, 10 jump index, 11 vector 0x40.
REQ-013 id_if_pcimd2ext, id_if_rega, id_if_pcindex  output  32 each  branch, register and index targets.
REQ-014 id_ex_instruc, id_ex_nextpc  output  32 each  registered instruction and PC+4 to execute.
REQ-015 id_ex_valid  output  1  id_ex_* holds a real instruction.
REQ-016 taken_cnt, stall_cnt  output  CNT_W each  saturating counts of taken redirects and operand-stall cycles.

Function
REQ-017 Decode SHALL be combinational from if_id_instruc:
- BEQ: op 000100.
- BNE: op 000101.
- J: op 000010.
- JAL: op 000011.
- JR: op 000000 with funct 001000.
- Everything else is non-control.
REQ-018 id_if_pcimd2ext SHALL equal if_id_nextpc + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-019 id_if_pcindex SHALL equal {if_id_nextpc[31:28], instr[25:0], 2'b00}.
REQ-020 id_if_rega SHALL equal rs_data.
REQ-021 Operand need:
- BEQ/BNE need rs and rt.
- JR needs rs.
- J/JAL need none.
REQ-022 opnd_wait SHALL be 1 when a needed operand's busy bit is 1 and the decode slot is not squashed.
REQ-023 id_stall SHALL equal (opnd_wait OR ex_stall) AND NOT exc_req.
REQ-024 Taken condition:
- BEQ taken when rs_data==rt_data.
- BNE taken when rs_data!=rt_data.
- J, JAL and JR are always taken.
REQ-025 id_if_selpcsource SHALL be 1 when exc_req=1, or when a taken control instruction is decoded with id_stall=0, ds_flag=0 and squash=0.
REQ-026 selpctype SHALL be 11 on exc_req, otherwise 00 for BEQ/BNE, 10 for J/JAL and 01 for JR.
REQ-027 The state machine SHALL have two states, RUN and WAIT.
- RUN->WAIT when opnd_wait=1 and exc_req=0.
- WAIT->RUN when opnd_wait=0, or on exc_req.
REQ-028 stall_cnt SHALL increment in every cycle spent in WAIT.
REQ-029 taken_cnt SHALL increment on each cycle with id_if_selpcsource=1 and selpctype!=11.
REQ-030 Both counters SHALL saturate at all-ones.
REQ-031 Delay slot: ds_flag SHALL be set for one accepted instruction after a taken branch/jump redirect. The instruction in that slot SHALL pass to execute normally, but its own control redirect is suppressed.
REQ-032 Exception squash: exc_req SHALL set squash for the next accepted instruction, which goes to execute with id_ex_valid=0. exc_req SHALL also clear ds_flag.
REQ-033 Pipeline register update:
- ex_stall=1 and exc_req=0: hold id_ex_*.
- exc_req=1 or opnd_wait=1: load id_ex_valid=0.
- Otherwise: load if_id_instruc/nextpc with id_ex_valid = NOT squash.
REQ-034 exc_req SHALL take priority over stall, ds_flag and branch decode in the same cycle.
REQ-035 JAL SHALL pass to execute unchanged; link write is execute's responsibility.

Reset
REQ-036 While reset=0, the following SHALL be 0 and state SHALL be RUN: id_ex_instruc, id_ex_nextpc, id_ex_valid, ds_flag, squash, taken_cnt, stall_cnt.
REQ-037 Reset asserted mid-WAIT SHALL return the block to RUN with counters cleared.
REQ-038 After reset, if_id_instruc=0 decodes as non-control; no redirect and no stall.

Verification
REQ-039 BEQ (imm 0x0003), nextpc=0x100, rs=rt=5, no busy -> same cycle selpcsource=1, type 00, pcimd2ext=0x10C; next edge taken_cnt=1, ds_flag=1.
REQ-040 BNE with rs=rt=7 -> selpcsource=0; pcimd2ext still computed; id_ex_valid=1 next cycle.
REQ-041 JR with rs_busy=1 for 3 cycles, rs_data=0x200 -> id_stall=1 for 3 cycles, 3 bubbles, stall_cnt=3; 4th cycle selpcsource=1, type 01, rega=0x200.
REQ-042 J at nextpc=0x3000_0010 followed by J in its delay slot -> first redirects to {0x3,instr[25:0],00}; second yields selpcsource=0 and passes with valid=1.
REQ-043 exc_req during WAIT -> id_stall=0, selpcsource=1, type 11, state RUN; next accepted instruction leaves with id_ex_valid=0.
REQ-044 ex_stall=1 for 2 cycles with BEQ taken in decode -> id_ex_* held, no redirect; redirect occurs on the cycle ex_stall drops.

Source files
------------

// File: rtl/id_branch_ctrl.sv
// Decode-stage branch/jump controller: resolves BEQ/BNE/J/JAL/JR in decode,
// handles operand stalls, delay slots, exception squash and perf counters.
module id_branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      if_id_nextpc,
  input  logic [31:0]      if_id_instruc,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             rs_busy,
  input  logic             rt_busy,
  input  logic             ex_stall,
  input  logic             exc_req,
  output logic             id_stall,
  output logic             id_if_selpcsource,
  output logic [1:0]       id_if_selpctype,
  output logic [31:0]      id_if_pcimd2ext,
  output logic [31:0]      id_if_rega,
  output logic [31:0]      id_if_pcindex,
  output logic [31:0]      id_ex_instruc,
  output logic [31:0]      id_ex_nextpc,
  output logic             id_ex_valid,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, WAIT} state_t;

  state_t state, state_next;
  logic   ds_flag, squash;

  logic [5:0] op, funct;
  logic       is_beq, is_bne, is_jump, is_jr;
  logic       need_rs, need_rt, opnd_wait, cond_taken, ctrl_redirect;

  assign op      = if_id_instruc[31:26];
  assign funct   = if_id_instruc[5:0];
  assign is_beq  = (op == 6'b000100);
  assign is_bne  = (op == 6'b000101);
  assign is_jump = (op == 6'b000010) || (op == 6'b000011);
  assign is_jr   = (op == 6'b000000) && (funct == 6'b001000);

  assign need_rs = is_beq || is_bne || is_jr;
  assign need_rt = is_beq || is_bne;

  // A squashed slot never waits: its result is discarded anyway.
  assign opnd_wait = ((need_rs && rs_busy) || (need_rt && rt_busy)) && !squash;
  assign id_stall  = (opnd_wait || ex_stall) && !exc_req;

  assign cond_taken = (is_beq && (rs_data == rt_data)) ||
                      (is_bne && (rs_data != rt_data)) ||
                      is_jump || is_jr;

  assign ctrl_redirect     = cond_taken && !id_stall && !ds_flag && !squash && !exc_req;
  assign id_if_selpcsource = exc_req || ctrl_redirect;

  assign id_if_pcimd2ext = if_id_nextpc + {{14{if_id_instruc[15]}}, if_id_instruc[15:0], 2'b00};
  assign id_if_pcindex   = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};
  assign id_if_rega      = rs_data;

  always_comb begin
    id_if_selpctype = 2'b00;
    if (exc_req)      id_if_selpctype = 2'b11;
    else if (is_jump) id_if_selpctype = 2'b10;
    else if (is_jr)   id_if_selpctype = 2'b01;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:  if (opnd_wait && !exc_req) state_next = WAIT;
      WAIT: if (!opnd_wait || exc_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Slot flags only advance when decode actually hands an instruction on.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ds_flag <= 1'b0;
      squash  <= 1'b0;
    end else if (exc_req) begin
      ds_flag <= 1'b0;
      squash  <= 1'b1;
    end else if (!id_stall) begin
      ds_flag <= ctrl_redirect;
      squash  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_instruc <= '0;
      id_ex_nextpc  <= '0;
      id_ex_valid   <= 1'b0;
    end else if (ex_stall && !exc_req) begin
      id_ex_valid <= id_ex_valid;
    end else if (exc_req || opnd_wait) begin
      id_ex_valid <= 1'b0;
    end else begin
      id_ex_instruc <= if_id_instruc;
      id_ex_nextpc  <= if_id_nextpc;
      id_ex_valid   <= !squash;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ctrl_redirect && (taken_cnt != '1)) taken_cnt <= taken_cnt + 1'b1;
      if ((state == WAIT) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
